// File: rtl/wf_rr_arbiter.sv
// Registered 16-way round-robin arbiter for wavefront slot selection.
// Rotates requests right by the priority pointer, picks the lowest bit, maps back and registers the grant.
module wf_rr_arbiter #(
  parameter logic [3:0] PTR_INIT = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        grant_ready,
  output logic        grant_valid,
  output logic [3:0]  grant_id,
  output logic [15:0] grant_onehot,
  output logic [3:0]  ptr
);

  logic        grantValid_q, grantValid_d;
  logic [3:0]  grantId_q, grantId_d;
  logic [15:0] grantOnehot_q, grantOnehot_d;
  logic [3:0]  ptr_q, ptr_d;

  logic        accept;
  logic        load;
  logic [3:0]  effPtr;
  logic [31:0] reqTwice;
  logic [31:0] reqShifted;
  logic [15:0] rot;
  logic [3:0]  lowIdx;
  logic [3:0]  winner;
  logic        found;

  // Arbitrate against the post-acceptance pointer so back-to-back grants already see the new priority.
  always_comb begin
    accept     = grantValid_q && grant_ready;
    load       = !grantValid_q || grant_ready;
    effPtr     = accept ? grantId_q + 4'd1 : ptr_q;
    reqTwice   = {req, req};
    reqShifted = reqTwice >> effPtr;
    rot        = reqShifted[15:0];
    found      = |req;
    lowIdx     = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rot[i]) begin
        lowIdx = 4'(i);
      end
    end
    winner = lowIdx + effPtr;
  end

  always_comb begin
    grantValid_d  = grantValid_q;
    grantId_d     = grantId_q;
    grantOnehot_d = grantOnehot_q;
    ptr_d         = ptr_q;
    if (accept) begin
      ptr_d = grantId_q + 4'd1;
    end
    if (load) begin
      grantValid_d  = found;
      grantOnehot_d = 16'd0;
      if (found) begin
        grantId_d     = winner;
        grantOnehot_d = 16'd1 << winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grantValid_q  <= 1'b0;
      grantId_q     <= 4'd0;
      grantOnehot_q <= 16'd0;
      ptr_q         <= PTR_INIT;
    end else begin
      grantValid_q  <= grantValid_d;
      grantId_q     <= grantId_d;
      grantOnehot_q <= grantOnehot_d;
      ptr_q         <= ptr_d;
    end
  end

  assign grant_valid  = grantValid_q;
  assign grant_id     = grantId_q;
  assign grant_onehot = grantOnehot_q;
  assign ptr          = ptr_q;

endmodule

// File: tb/tb_wf_rr_arbiter.sv
// Directed bench for wf_rr_arbiter: rotation, wrap, backpressure, idle, fairness and async reset.
module tb_wf_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        grantReady;
  logic        grantValid;
  logic [3:0]  grantId;
  logic [15:0] grantOnehot;
  logic [3:0]  ptr;

  int errors = 0;
  int checks = 0;

  wf_rr_arbiter #(.PTR_INIT(4'd0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .grant_ready  (grantReady),
    .grant_valid  (grantValid),
    .grant_id     (grantId),
    .grant_onehot (grantOnehot),
    .ptr          (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [15:0] reqVal, input logic readyVal);
    req        = reqVal;
    grantReady = readyVal;
  endtask

  // Advance one rising edge and settle just after it, so outputs are read away from the edge.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkGrant(input string tag, input logic v, input logic [3:0] id,
                            input logic [15:0] oh, input logic [3:0] p);
    checkOutput({tag, "_valid"}, 32'(grantValid), 32'(v));
    checkOutput({tag, "_id"}, 32'(grantId), 32'(id));
    checkOutput({tag, "_onehot"}, 32'(grantOnehot), 32'(oh));
    checkOutput({tag, "_ptr"}, 32'(ptr), 32'(p));
  endtask

  initial begin
    logic [3:0] expNext;
    rst_n = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    #3;
    checkGrant("reset", 1'b0, 4'd0, 16'h0000, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic rotation: ids 2, 4, 2.
    applyStimulus(16'h0014, 1'b1);
    stepClk();
    checkGrant("rot1", 1'b1, 4'd2, 16'h0004, 4'd0);
    stepClk();
    checkGrant("rot2", 1'b1, 4'd4, 16'h0010, 4'd3);
    stepClk();
    checkGrant("rot3", 1'b1, 4'd2, 16'h0004, 4'd5);

    // Wrap-around: accept id 14 so ptr becomes 15, then alternate 0/14.
    applyStimulus(16'h4000, 1'b1);
    stepClk();
    checkGrant("wrapPrep", 1'b1, 4'd14, 16'h4000, 4'd3);
    applyStimulus(16'h4001, 1'b1);
    stepClk();
    checkGrant("wrap1", 1'b1, 4'd0, 16'h0001, 4'd15);
    stepClk();
    checkGrant("wrap2", 1'b1, 4'd14, 16'h4000, 4'd1);
    stepClk();
    checkGrant("wrap3", 1'b1, 4'd0, 16'h0001, 4'd15);

    // Backpressure: id 8 held while req moves to slot 15.
    applyStimulus(16'h0100, 1'b1);
    stepClk();
    checkGrant("bpLoad", 1'b1, 4'd8, 16'h0100, 4'd1);
    applyStimulus(16'h8000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkGrant("bpHold", 1'b1, 4'd8, 16'h0100, 4'd1);
    end
    applyStimulus(16'h8000, 1'b1);
    stepClk();
    checkGrant("bpRelease", 1'b1, 4'd15, 16'h8000, 4'd9);

    // Idle: no requests, pointer parks after the last acceptance.
    applyStimulus(16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkGrant("idle", 1'b0, 4'd15, 16'h0000, 4'd0);
    end
    applyStimulus(16'hFFFF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      stepClk();
      checkGrant("sweep", 1'b1, 4'(i), 16'h0001 << i, 4'(i));
    end

    // Fairness: with all slots requesting, accepted ids must step by one.
    expNext = 4'd15;
    for (int c = 0; c < 1000; c++) begin
      grantReady = 1'($urandom_range(0, 1));
      if (grantValid && grantReady) begin
        checkOutput("fairId", 32'(grantId), 32'(expNext));
        checkOutput("fairOnehot", 32'(grantOnehot), 32'(16'h0001 << expNext));
        expNext = expNext + 4'd1;
      end
      stepClk();
    end

    // Reset mid-handshake while id 7 is presented.
    applyStimulus(16'h0080, 1'b1);
    stepClk();
    applyStimulus(16'h0080, 1'b0);
    stepClk();
    checkGrant("preRst", 1'b1, 4'd7, 16'h0080, ptr);
    #2;
    rst_n = 1'b0;
    #1;
    checkGrant("asyncRst", 1'b0, 4'd0, 16'h0000, 4'd0);
    applyStimulus(16'h0080, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    stepClk();
    checkGrant("postRst", 1'b1, 4'd7, 16'h0080, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wf_rr_arbiter.md
# wf_rr_arbiter

Registered 16-way round-robin arbiter for wavefront slot selection, and the companion to the 16-bit circular rotate-right primitive. It rotates the request vector right by the current priority pointer and picks the lowest set bit. It then maps that winner back to absolute slot space (the inverse, rotate-left direction) and presents it downstream through a valid/ready handshake. The priority pointer advances past each accepted winner, so every requesting slot is served within 16 accepted grants.

## Interface
- PTR_INIT, 0: priority pointer value after reset (0..15); the slot at this index has highest priority first.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  16  per-slot request levels; bit i = slot i requesting.
- grant_ready  input  1  downstream accepts the presented grant this cycle.
- grant_valid  output  1  a grant is presented.
- grant_id  output  4  index of granted slot.
- grant_onehot  output  16  one-hot of grant_id; all-zero when grant_valid=0.
- ptr  output  4  current priority pointer, exposed for debug and verification.

## Operation
- Arbitration is combinational from req and an effective pointer P.
  - rot[i] = req[(i+P) mod 16], i.e. rotate right by P.
  - k = lowest set index of rot.
  - winner = (k+P) mod 16, computed as a 4-bit wrap-around add.
  - found = |req.
- P = ptr when the output register is not being accepted this cycle.
- P = grant_id+1 (mod 16) when grant_valid && grant_ready, so a back-to-back arbitration already sees the updated priority.
- The output register loads when !grant_valid || grant_ready ("load" cycle):
  - grant_valid <= found.
  - grant_id <= winner if found, else unchanged.
  - grant_onehot <= 1<<winner if found, else 0.
- Hold: while grant_valid && !grant_ready, grant_id, grant_onehot and grant_valid hold stable. This applies even if req changes or the granted bit drops. A registered grant is never withdrawn.
- Pointer update: on each accepted cycle (grant_valid && grant_ready), ptr <= grant_id+1 mod 16. Otherwise ptr holds. An idle cycle (no valid grant) never moves ptr.
- Pointer wrap: grant_id=15 accepted gives ptr=0.
- A slot still requesting after acceptance stays eligible at lowest priority; a single lone requester is granted every cycle.
- grant_onehot is always exactly 1<<grant_id when valid.
- Reset asserted, including mid-handshake:
  - grant_valid=0, grant_id=0, grant_onehot=0, ptr=PTR_INIT, all immediately (asynchronous).
  - Any pending grant is discarded.
  - Reset deassertion is synchronized externally; the first load happens on the first rising edge with rst_n=1.

## Timing
- Latency: req sampled at edge N produces grant_valid at N+1 (one register stage). No combinational path from req to outputs.
- grant_ready affects only register loading; there is no combinational path from grant_ready to any output.
- Throughput: one grant per cycle while grant_ready=1 and req is non-zero.
- Reset values: grant_valid 0, grant_id 0, grant_onehot 0x0000, ptr PTR_INIT.
- Combinational depth: 4-level rotate, 16-bit priority encode, 4-bit add. This must close at the core clock without pipelining.

## Test plan
- Basic rotation:
  - Stimulus: PTR_INIT=0, req=0x0014, grant_ready=1.
  - Response: cycle 1 gives id 2, onehot 0x0004, ptr then 3. Cycle 2 gives id 4, ptr 5. Cycle 3 gives id 2 again.
- Wrap-around:
  - Stimulus: ptr forced to 15 by accepting id 14, then req=0x4001.
  - Response: grant id 0, then 14, then 0. ptr sequence 1, 15, 1.
- Backpressure:
  - Stimulus: req=0x0100, grant_ready=0 for 3 cycles while req changes to 0x8000.
  - Response: grant_valid=1, id 8 held all 3 cycles and ptr unchanged. After grant_ready=1 for one cycle, ptr=9 and next grant id 15.
- Idle:
  - Stimulus: req=0x0000 for 5 cycles.
  - Response: grant_valid=0, onehot 0x0000, ptr constant. Then req=0xFFFF gives grants starting at ptr, in consecutive order over 16 cycles.
- Fairness:
  - Stimulus: req=0xFFFF, grant_ready random with 50% probability, 1000 cycles.
  - Response: accepted ids form a strict cyclic sequence, and every slot is served within any 16 consecutive accepts.
- Reset mid-operation:
  - Stimulus: rst_n low between edges while grant_valid=1, id 7.
  - Response: outputs zero and ptr=PTR_INIT immediately, without waiting for a clock edge. After release with req=0x0080, the first grant id is 7 one cycle later.
